// File: rtl/ecc_harq_tx.sv
// ecc_harq_tx
// Transmit stage for a NoC link. Appends a check byte to each 32-bit payload
// word to form a 40-bit flit, keeps every sent flit in a replay buffer until it
// is acknowledged, and retransmits go-back-N from the oldest unacknowledged flit
// when the receiver NACKs it. After MAX_RETRY NACKs on the same oldest flit, the
// next NACK drops that flit and pulses o_fail.
//
// Ports
//   i_aclk, i_areset          clock, asynchronous active-high reset
//   i_enable_ecc              1: check byte = {8{^payload}}, 0: check byte = 8'h00
//   i_wvalid/i_wdata/o_wready payload input handshake
//   o_wvalid/o_wdata          flit output, [39:32] check byte, [31:0] payload
//   i_ack/i_nack              one-cycle receiver responses for the oldest flit
//   o_retx                    current output beat is a replay
//   o_fail                    one-cycle pulse when the oldest flit is dropped
//   o_outstanding             number of unacknowledged flits (0..DEPTH)
//
// Optional build macro ECC_HARQ_TX_ERR_INJECT_EN adds i_inj_serr/i_inj_derr.
// These corrupt bit 0 (single) or bits 1:0 (double) of the emitted beat only.
// The replay buffer always holds clean flits.
//
// state  | meaning
// SEND   | accepting new payload, each accepted word is emitted the next cycle
// REPLAY | payload stalled, re-emitting buffer entries rp_ptr .. wr_ptr-1

module ecc_harq_tx #(
    parameter int DEPTH     = 8,
    parameter int MAX_RETRY = 3
) (
    input  logic                     i_aclk,
    input  logic                     i_areset,
    input  logic                     i_enable_ecc,
    input  logic                     i_wvalid,
    input  logic [31:0]              i_wdata,
    output logic                     o_wready,
    output logic                     o_wvalid,
    output logic [39:0]              o_wdata,
    input  logic                     i_ack,
    input  logic                     i_nack,
`ifdef ECC_HARQ_TX_ERR_INJECT_EN
    input  logic                     i_inj_serr,
    input  logic                     i_inj_derr,
`endif
    output logic                     o_retx,
    output logic                     o_fail,
    output logic [$clog2(DEPTH):0]   o_outstanding
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [RW-1:0] MAX_R   = RW'(MAX_RETRY);

    typedef enum logic {ST_SEND, ST_REPLAY} state_t;

    state_t          state;
    logic [39:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   old_ptr;
    logic [AW-1:0]   rp_ptr;
    logic [RW-1:0]   retry;

    logic            accept;
    logic            ack_eff;
    logic            nack_eff;
    logic            do_retry;
    logic            do_drop;
    logic            replay_beat;
    logic            last_beat;
    logic            beat;
    logic [CW-1:0]   count_a;
    logic [CW-1:0]   count_n;
    logic [AW-1:0]   old_a;
    logic [AW-1:0]   rp_eff;
    logic [RW-1:0]   retry_a;
    logic [39:0]     flit_in;
    logic [39:0]     beat_data;
    logic [39:0]     out_data;

    assign o_wready = !i_areset && (state == ST_SEND) && (o_outstanding < DEPTH_C);

    // The ACK is resolved first. The NACK is then judged against the flit that
    // is oldest after that ACK.
    always_comb begin
        accept      = i_wvalid && o_wready;
        ack_eff     = i_ack && (o_outstanding != '0);
        count_a     = o_outstanding - CW'(ack_eff);
        old_a       = old_ptr + AW'(ack_eff);
        retry_a     = ack_eff ? '0 : retry;
        nack_eff    = i_nack && (count_a != '0);
        do_retry    = nack_eff && (retry_a < MAX_R);
        do_drop     = nack_eff && !do_retry;
        count_n     = count_a + CW'(accept) - CW'(do_drop);
        flit_in     = {(i_enable_ecc ? {8{^i_wdata}} : 8'h00), i_wdata};
        // An ACK for the entry under the replay cursor skips that entry.
        rp_eff      = (ack_eff && (rp_ptr == old_ptr)) ? rp_ptr + AW'(1) : rp_ptr;
        replay_beat = (state == ST_REPLAY) && (count_a != '0);
        last_beat   = (rp_eff == wr_ptr - AW'(1));
        beat        = accept || replay_beat;
        beat_data   = accept ? flit_in : mem[rp_eff];
`ifdef ECC_HARQ_TX_ERR_INJECT_EN
        out_data    = beat_data ^ {38'b0, i_inj_derr, i_inj_serr | i_inj_derr};
`else
        out_data    = beat_data;
`endif
    end

    // The buffer has no reset. An entry is only read after it has been written.
    always_ff @(posedge i_aclk) begin
        if (accept) begin
            mem[wr_ptr] <= flit_in;
        end
    end

    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            state         <= ST_SEND;
            wr_ptr        <= '0;
            old_ptr       <= '0;
            rp_ptr        <= '0;
            retry         <= '0;
            o_outstanding <= '0;
            o_wvalid      <= 1'b0;
            o_wdata       <= 40'h0;
            o_retx        <= 1'b0;
            o_fail        <= 1'b0;
        end else begin
            o_wvalid      <= beat;
            o_retx        <= replay_beat;
            o_fail        <= do_drop;
            if (beat) begin
                o_wdata <= out_data;
            end
            if (accept) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            o_outstanding <= count_n;
            old_ptr       <= old_a + AW'(do_drop);

            if (do_retry) begin
                retry <= retry_a + RW'(1);
            end else if (do_drop) begin
                retry <= '0;
            end else begin
                retry <= retry_a;
            end

            if (state == ST_REPLAY) begin
                if (count_a == '0) begin
                    state <= ST_SEND;
                end else begin
                    rp_ptr <= rp_eff + AW'(1);
                    if (last_beat) begin
                        state <= ST_SEND;
                    end
                end
            end

            // A NACK overrides the cursor and state chosen above.
            if (do_retry) begin
                rp_ptr <= old_a;
                state  <= ST_REPLAY;
            end else if (do_drop) begin
                if (count_n != '0) begin
                    rp_ptr <= old_a + AW'(1);
                    state  <= ST_REPLAY;
                end else begin
                    state  <= ST_SEND;
                end
            end
        end
    end

endmodule

// File: tb/tb_ecc_harq_tx.sv
module tb_ecc_harq_tx;

    logic        i_aclk = 1'b0;
    logic        i_areset;
    logic        i_enable_ecc;
    logic        i_wvalid;
    logic [31:0] i_wdata;
    logic        o_wready;
    logic        o_wvalid;
    logic [39:0] o_wdata;
    logic        i_ack;
    logic        i_nack;
    logic        o_retx;
    logic        o_fail;
    logic [3:0]  o_outstanding;
`ifdef ECC_HARQ_TX_ERR_INJECT_EN
    logic        i_inj_serr = 1'b0;
    logic        i_inj_derr = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    // Expected flits for D0..D3 = 1, 3, 7, F with the check byte enabled.
    logic [39:0] exp_d [4] = '{40'hFF_0000_0001, 40'h00_0000_0003,
                               40'hFF_0000_0007, 40'h00_0000_000F};
    logic [31:0] dat_d [4] = '{32'h1, 32'h3, 32'h7, 32'hF};

    always #5 i_aclk = ~i_aclk;

    ecc_harq_tx #(.DEPTH(8), .MAX_RETRY(3)) dut (
        .i_aclk        (i_aclk),
        .i_areset      (i_areset),
        .i_enable_ecc  (i_enable_ecc),
        .i_wvalid      (i_wvalid),
        .i_wdata       (i_wdata),
        .o_wready      (o_wready),
        .o_wvalid      (o_wvalid),
        .o_wdata       (o_wdata),
        .i_ack         (i_ack),
        .i_nack        (i_nack),
`ifdef ECC_HARQ_TX_ERR_INJECT_EN
        .i_inj_serr    (i_inj_serr),
        .i_inj_derr    (i_inj_derr),
`endif
        .o_retx        (o_retx),
        .o_fail        (o_fail),
        .o_outstanding (o_outstanding)
    );

    task automatic tick();
        @(posedge i_aclk);
        #1;
    endtask

    task automatic do_reset();
        i_areset     = 1'b1;
        i_enable_ecc = 1'b1;
        i_wvalid     = 1'b0;
        i_wdata      = '0;
        i_ack        = 1'b0;
        i_nack       = 1'b0;
        tick();
        tick();
        i_areset     = 1'b0;
    endtask

    task automatic send_d(input int n);
        for (int i = 0; i < n; i++) begin
            i_wvalid = 1'b1;
            i_wdata  = dat_d[i];
            tick();
        end
        i_wvalid = 1'b0;
    endtask

    task automatic test_reset();
        i_areset = 1'b1; i_enable_ecc = 1'b1; i_wvalid = 1'b1; i_wdata = 32'h1;
        i_ack = 1'b0; i_nack = 1'b0;
        tick();
        checks++; if (o_wvalid !== 1'b0) begin errors++; $display("FAIL reset_wvalid got %b exp 0", o_wvalid); end
        checks++; if (o_wdata !== 40'h0) begin errors++; $display("FAIL reset_wdata got %h exp 0", o_wdata); end
        checks++; if (o_retx !== 1'b0 || o_fail !== 1'b0) begin errors++; $display("FAIL reset_retx_fail got %b%b exp 00", o_retx, o_fail); end
        checks++; if (o_outstanding !== 4'd0) begin errors++; $display("FAIL reset_outstanding got %0d exp 0", o_outstanding); end
        checks++; if (o_wready !== 1'b0) begin errors++; $display("FAIL reset_wready got %b exp 0", o_wready); end
        i_wvalid = 1'b0;
        i_areset = 1'b0;
        #1;
        checks++; if (o_wready !== 1'b1) begin errors++; $display("FAIL post_reset_wready got %b exp 1", o_wready); end
    endtask

    task automatic test_ecc();
        do_reset();
        i_enable_ecc = 1'b1; i_wvalid = 1'b1; i_wdata = 32'hA5A5_0001;
        tick();
        checks++; if (o_wvalid !== 1'b1 || o_retx !== 1'b0) begin errors++; $display("FAIL ecc_on_valid got v=%b r=%b exp v=1 r=0", o_wvalid, o_retx); end
        checks++; if (o_wdata !== 40'hFF_A5A5_0001) begin errors++; $display("FAIL ecc_on_data got %h exp ffa5a50001", o_wdata); end
        checks++; if (o_outstanding !== 4'd1) begin errors++; $display("FAIL ecc_on_outstanding got %0d exp 1", o_outstanding); end
        i_enable_ecc = 1'b0;
        tick();
        checks++; if (o_wdata !== 40'h00_A5A5_0001) begin errors++; $display("FAIL ecc_off_data got %h exp 00a5a50001", o_wdata); end
        i_wvalid = 1'b0; i_enable_ecc = 1'b1;
        tick();
        checks++; if (o_wvalid !== 1'b0) begin errors++; $display("FAIL idle_wvalid got %b exp 0", o_wvalid); end
        checks++; if (o_wdata !== 40'h00_A5A5_0001) begin errors++; $display("FAIL idle_hold_data got %h exp 00a5a50001", o_wdata); end
        checks++; if (o_outstanding !== 4'd2) begin errors++; $display("FAIL idle_outstanding got %0d exp 2", o_outstanding); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            i_wvalid = 1'b1; i_wdata = 32'h100 + i;
            tick();
        end
        checks++; if (o_outstanding !== 4'd8) begin errors++; $display("FAIL full_outstanding got %0d exp 8", o_outstanding); end
        checks++; if (o_wready !== 1'b0) begin errors++; $display("FAIL full_wready got %b exp 0", o_wready); end
        i_wdata = 32'h200;
        tick();
        checks++; if (o_wvalid !== 1'b0 || o_outstanding !== 4'd8) begin errors++; $display("FAIL full_stall got v=%b n=%0d exp v=0 n=8", o_wvalid, o_outstanding); end
        i_ack = 1'b1;
        tick();
        i_ack = 1'b0; i_wvalid = 1'b0;
        checks++; if (o_outstanding !== 4'd7) begin errors++; $display("FAIL full_ack_outstanding got %0d exp 7", o_outstanding); end
        checks++; if (o_wready !== 1'b1) begin errors++; $display("FAIL full_ack_wready got %b exp 1", o_wready); end
    endtask

    task automatic test_replay();
        do_reset();
        send_d(4);
        i_nack = 1'b1;
        tick();
        i_nack = 1'b0;
        checks++; if (o_wready !== 1'b0 || o_wvalid !== 1'b0) begin errors++; $display("FAIL nack_wready_wvalid got %b%b exp 00", o_wready, o_wvalid); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (o_wvalid !== 1'b1 || o_retx !== 1'b1 || o_wdata !== exp_d[i]) begin
                errors++; $display("FAIL replay_beat%0d got v=%b r=%b d=%h exp v=1 r=1 d=%h", i, o_wvalid, o_retx, o_wdata, exp_d[i]);
            end
        end
        tick();
        checks++; if (o_wvalid !== 1'b0 || o_retx !== 1'b0 || o_wready !== 1'b1) begin errors++; $display("FAIL replay_end got v=%b r=%b rdy=%b exp 0 0 1", o_wvalid, o_retx, o_wready); end
        checks++; if (o_outstanding !== 4'd4) begin errors++; $display("FAIL replay_outstanding got %0d exp 4", o_outstanding); end
        // ACK on the first replay cycle releases D0, so the replay is D1..D3.
        i_nack = 1'b1;
        tick();
        i_nack = 1'b0; i_ack = 1'b1;
        for (int i = 1; i < 4; i++) begin
            tick();
            i_ack = 1'b0;
            checks++;
            if (o_wvalid !== 1'b1 || o_retx !== 1'b1 || o_wdata !== exp_d[i]) begin
                errors++; $display("FAIL short_replay_beat%0d got v=%b r=%b d=%h exp v=1 r=1 d=%h", i, o_wvalid, o_retx, o_wdata, exp_d[i]);
            end
        end
        tick();
        checks++; if (o_wvalid !== 1'b0 || o_outstanding !== 4'd3) begin errors++; $display("FAIL short_replay_end got v=%b n=%0d exp v=0 n=3", o_wvalid, o_outstanding); end
    endtask

    task automatic test_fail();
        do_reset();
        send_d(1);
        for (int k = 0; k < 3; k++) begin
            i_nack = 1'b1;
            tick();
            i_nack = 1'b0;
            checks++; if (o_fail !== 1'b0) begin errors++; $display("FAIL retry%0d_fail got %b exp 0", k, o_fail); end
            tick();
            checks++;
            if (o_wvalid !== 1'b1 || o_retx !== 1'b1 || o_wdata !== exp_d[0]) begin
                errors++; $display("FAIL retry%0d_beat got v=%b r=%b d=%h exp v=1 r=1 d=%h", k, o_wvalid, o_retx, o_wdata, exp_d[0]);
            end
            tick();
        end
        i_nack = 1'b1;
        tick();
        i_nack = 1'b0;
        checks++; if (o_fail !== 1'b1) begin errors++; $display("FAIL drop_fail got %b exp 1", o_fail); end
        checks++; if (o_outstanding !== 4'd0 || o_wready !== 1'b1) begin errors++; $display("FAIL drop_state got n=%0d rdy=%b exp n=0 rdy=1", o_outstanding, o_wready); end
        tick();
        checks++; if (o_fail !== 1'b0 || o_wvalid !== 1'b0) begin errors++; $display("FAIL drop_after got f=%b v=%b exp 0 0", o_fail, o_wvalid); end
    endtask

    task automatic test_ack_nack();
        do_reset();
        send_d(2);
        i_ack = 1'b1; i_nack = 1'b1;
        tick();
        i_ack = 1'b0; i_nack = 1'b0;
        checks++; if (o_outstanding !== 4'd1) begin errors++; $display("FAIL acknack_outstanding got %0d exp 1", o_outstanding); end
        tick();
        checks++;
        if (o_wvalid !== 1'b1 || o_retx !== 1'b1 || o_wdata !== exp_d[1]) begin
            errors++; $display("FAIL acknack_beat got v=%b r=%b d=%h exp v=1 r=1 d=%h", o_wvalid, o_retx, o_wdata, exp_d[1]);
        end
        tick();
        checks++; if (o_wvalid !== 1'b0 || o_wready !== 1'b1 || o_outstanding !== 4'd1) begin errors++; $display("FAIL acknack_end got v=%b rdy=%b n=%0d exp 0 1 1", o_wvalid, o_wready, o_outstanding); end
    endtask

    task automatic test_reset_mid_replay();
        do_reset();
        send_d(3);
        i_nack = 1'b1;
        tick();
        i_nack = 1'b0;
        tick();
        checks++; if (o_retx !== 1'b1) begin errors++; $display("FAIL mid_pre_retx got %b exp 1", o_retx); end
        i_areset = 1'b1;
        #1;
        checks++; if (o_wvalid !== 1'b0 || o_outstanding !== 4'd0 || o_wready !== 1'b0) begin errors++; $display("FAIL mid_reset got v=%b n=%0d rdy=%b exp 0 0 0", o_wvalid, o_outstanding, o_wready); end
        tick();
        i_areset = 1'b0;
        i_wvalid = 1'b1; i_wdata = 32'h0000_0003;
        tick();
        i_wvalid = 1'b0;
        checks++;
        if (o_wvalid !== 1'b1 || o_retx !== 1'b0 || o_wdata !== 40'h00_0000_0003 || o_outstanding !== 4'd1) begin
            errors++; $display("FAIL mid_first_accept got v=%b r=%b d=%h n=%0d exp 1 0 0000000003 1", o_wvalid, o_retx, o_wdata, o_outstanding);
        end
    endtask

    initial begin
        test_reset();
        test_ecc();
        test_full();
        test_replay();
        test_fail();
        test_ack_nack();
        test_reset_mid_replay();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ecc_harq_tx.md
Name: ecc_harq_tx

Overview:
- Transmit-side stage directly upstream of the SECDED receive checker on each NoC link.
- Takes 32-bit payload words with a valid/ready handshake and appends the 8-bit check byte to form the 40-bit link flit.
- Keeps every sent flit in a replay buffer until the receiver acknowledges it.
- On NACK, retransmits go-back-N from the oldest unacknowledged flit, with a bounded retry count.

Parameters:
- DEPTH, 8, replay buffer entries (power of 2, ≥2); also the maximum number of outstanding flits.
- MAX_RETRY, 3, NACKs tolerated for the oldest flit before it is dropped.

Ports:
- i_aclk  in  1  clock.
- i_areset  in  1  asynchronous reset, active-high.
- i_enable_ecc  in  1  1: generate check byte; 0: check byte = 8'h00.
- i_wvalid  in  1  payload valid.
- i_wdata  in  32  payload.
- o_wready  out  1  payload accepted when i_wvalid & o_wready.
- o_wvalid  out  1  flit valid on link.
- o_wdata  out  40  flit; [39:32] check byte, [31:0] payload.
- i_ack  in  1  one-cycle pulse; receiver accepted the oldest outstanding flit.
- i_nack  in  1  one-cycle pulse; receiver rejected the oldest outstanding flit.
- o_retx  out  1  current o_wvalid beat is a replay.
- o_fail  out  1  one-cycle pulse; oldest flit dropped after MAX_RETRY.
- o_outstanding  out  $clog2(DEPTH)+1  count of unacknowledged flits.

Behaviour:
- Reset (async, i_areset=1) clears o_wvalid, o_wdata=40'h0, o_retx, o_fail, o_outstanding, all pointers and the retry counter, and enters SEND. o_wready is 0 while reset is asserted.
- Check byte:
  - When i_enable_ecc=1, all 8 bits equal ^i_wdata[31:0], i.e. {8{^data}}. This is bit-exact with the receiver's check generator.
  - The check byte is computed at acceptance and stored with the flit. Replays resend the stored byte unchanged.
- Pointers and count:
  - wr_ptr: next free entry.
  - old_ptr: oldest unacknowledged entry.
  - rp_ptr: replay cursor.
  - All wrap modulo DEPTH.
  - count = o_outstanding, range 0..DEPTH.
- State SEND:
  - o_wready = (count < DEPTH).
  - On accept: store the flit at wr_ptr, wr_ptr++, count++. Next cycle o_wvalid=1, o_wdata=flit, o_retx=0. Latency is 1 cycle.
  - When count==DEPTH, o_wready=0 and input stalls until an ACK arrives.
- i_ack:
  - With count>0: old_ptr++, count--, retry counter cleared.
  - With count==0: ignored.
- i_nack with count>0:
  - If retry < MAX_RETRY: retry++, rp_ptr=old_ptr, go to REPLAY.
  - Else: pulse o_fail, drop the oldest flit (old_ptr++, count--), retry cleared. If count after the drop > 0, go to REPLAY from the new oldest; otherwise stay in SEND.
- i_nack with count==0: ignored.
- State REPLAY:
  - o_wready=0.
  - Each cycle emits entry rp_ptr with o_wvalid=1, o_retx=1, then rp_ptr++.
  - Returns to SEND after emitting entry wr_ptr-1.
- NACK during REPLAY: restart from old_ptr, subject to the same retry rule.
- ACK during REPLAY:
  - Advances old_ptr.
  - If rp_ptr equalled the old old_ptr, rp_ptr also advances.
  - If count becomes 0, return to SEND.
- Simultaneous i_ack & i_nack: the ACK is applied first, then the NACK is evaluated against the new oldest flit. If count is then 0, the NACK is ignored.
- Simultaneous accept and ACK in SEND: count is unchanged, both pointers advance.
- o_wvalid=0 in any cycle with no accept and no replay beat. o_wdata holds its last value.
- i_enable_ecc is sampled at acceptance only.

Optional Feature:
- Macro ECC_HARQ_TX_ERR_INJECT_EN.
- When defined, adds ports i_inj_serr (in, 1) and i_inj_derr (in, 1), sampled on the beat being emitted:
  - i_inj_serr flips o_wdata[0].
  - i_inj_derr flips o_wdata[0] and o_wdata[1].
  - Stored buffer contents are never modified, so a replay carries clean data.
- When undefined, the ports do not exist and o_wdata is exactly the stored flit.

Test Plan:
- Reset, then send 32'hA5A5_0001 (parity 1) with ECC on → next cycle o_wvalid=1, o_wdata=40'hFF_A5A5_0001, o_retx=0, o_outstanding=1. With ECC off → o_wdata=40'h00_A5A5_0001.
- Send 8 words without ACK → o_wready=0 after the 8th and o_outstanding=8. One i_ack → o_wready=1 next cycle, o_outstanding=7.
- Send words D0..D3, then i_nack → o_wready=0 and a 4-cycle replay D0,D1,D2,D3 with o_retx=1, then return to SEND. An i_ack arriving during the replay shortens the replay as specified.
- Send D0, then 4 consecutive i_nack (each after its replay) → the first 3 replay D0, the 4th pulses o_fail, o_outstanding=0, no replay.
- Send D0, D1, then i_ack and i_nack in the same cycle → D0 released, replay of D1 only, o_outstanding=1.
- Assert i_areset mid-replay → o_wvalid=0 and o_outstanding=0 immediately. After release, a new word is accepted in the first cycle.
